// File: rtl/harris_line_window_buffer_pkg.sv
// Shared types and width helpers for the Harris line window buffer.
package harris_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    SCAN = 2'd1,
    LOAD = 2'd2
  } state_t;

  localparam int DEF_PIX_W       = 8;
  localparam int DEF_LINE_LEN    = 480;
  localparam int DEF_NUM_LINES   = 7;
  localparam int DEF_FRAME_LINES = 640;

  // Counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    int r;
    r = $clog2(v);
    return (r < 1) ? 1 : r;
  endfunction

  localparam int DEF_COL_W  = clog2_min1(DEF_LINE_LEN);
  localparam int DEF_SLOT_W = clog2_min1(DEF_NUM_LINES);
  localparam int DEF_LINE_W = clog2_min1(DEF_FRAME_LINES + 1);

endpackage

// File: rtl/harris_line_window_buffer_ram.sv
// One image line of storage: single write port, single synchronous read port.
module harris_line_ram #(
  parameter int PIX_W = 8,
  parameter int DEPTH = 480,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  // Write and registered read; rdata holds while re is low so a stalled
  // window pipeline keeps its pending column.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/harris_line_window_buffer.sv
// Circular line buffer: holds NUM_LINES lines, streams column windows
// (oldest line in lane 0) and requests one new line per completed pass.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  FILL  | write NUM_LINES fresh lines into slots 0..NUM_LINES-1
//  SCAN  | stream LINE_LEN column windows, pixels are dropped
//  LOAD  | overwrite the oldest slot (head) with one new line
module harris_line_window_buffer
  import harris_pkg::*;
#(
  parameter int PIX_W       = DEF_PIX_W,
  parameter int LINE_LEN    = DEF_LINE_LEN,
  parameter int NUM_LINES   = DEF_NUM_LINES,
  parameter int FRAME_LINES = DEF_FRAME_LINES
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIX_W-1:0]           pixel,
  input  logic                       pixel_valid,
  output logic [NUM_LINES*PIX_W-1:0] win_col,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic                       win_last,
  output logic                       intrpt,
  output logic                       frame_done,
  output logic                       overflow
);

  localparam int CW = clog2_min1(LINE_LEN);
  localparam int SW = clog2_min1(NUM_LINES);
  localparam int LW = clog2_min1(FRAME_LINES + 1);

  state_t state, state_nxt;

  logic [CW-1:0] wr_col, rd_col;
  logic [SW-1:0] head, wr_slot, wr_sel;
  logic [LW-1:0] lines_in;
  logic          iss_done, s1_valid, s1_last;
  logic          wr_en, issue, ovf_set;
  logic [PIX_W-1:0]           ram_q [NUM_LINES];
  logic [NUM_LINES*PIX_W-1:0] lanes;
  logic [SW:0]                lane_slot;

  logic wr_col_last, rd_col_last, slot_last, head_last;
  logic adv, pass_end, frame_end, fill_done, line_done;

  assign wr_col_last = (wr_col == CW'(LINE_LEN - 1));
  assign rd_col_last = (rd_col == CW'(LINE_LEN - 1));
  assign slot_last   = (wr_slot == SW'(NUM_LINES - 1));
  assign head_last   = (head == SW'(NUM_LINES - 1));
  assign adv         = !win_valid || win_ready;
  assign pass_end    = win_valid && win_ready && win_last;
  assign frame_end   = pass_end && (lines_in == LW'(FRAME_LINES));
  assign line_done   = wr_en && wr_col_last;
  assign fill_done   = (state == FILL) && line_done && slot_last;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FILL;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (fill_done) state_nxt = SCAN;
      SCAN:    if (pass_end)  state_nxt = frame_end ? FILL : LOAD;
      LOAD:    if (line_done) state_nxt = SCAN;
      default: state_nxt = FILL;
    endcase
  end

  // State-dependent control strobes.
  always_comb begin
    wr_en   = pixel_valid && ((state == FILL) || (state == LOAD));
    wr_sel  = (state == LOAD) ? head : wr_slot;
    issue   = (state == SCAN) && adv && !iss_done;
    ovf_set = pixel_valid && (state == SCAN);
  end

  // Write-side counters, line bookkeeping and head rotation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_col   <= '0;
      wr_slot  <= '0;
      head     <= '0;
      lines_in <= '0;
    end else begin
      if (wr_en) wr_col <= wr_col_last ? '0 : wr_col + 1'b1;
      if (frame_end) begin
        wr_slot  <= '0;
        head     <= '0;
        lines_in <= '0;
      end else if (line_done) begin
        lines_in <= lines_in + 1'b1;
        if (state == FILL) wr_slot <= slot_last ? '0 : wr_slot + 1'b1;
        else               head    <= head_last ? '0 : head + 1'b1;
      end
    end
  end

  // Read-address issue; one read per pass column, paced by the output stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_col   <= '0;
      iss_done <= 1'b0;
    end else if (state != SCAN) begin
      rd_col   <= '0;
      iss_done <= 1'b0;
    end else if (issue) begin
      rd_col   <= rd_col_last ? '0 : rd_col + 1'b1;
      iss_done <= rd_col_last;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_LINES; g++) begin : g_line
      harris_line_ram #(
        .PIX_W (PIX_W),
        .DEPTH (LINE_LEN),
        .AW    (CW)
      ) u_ram (
        .clk   (clk),
        .we    (wr_en && (wr_sel == SW'(g))),
        .waddr (wr_col),
        .wdata (pixel),
        .re    (issue),
        .raddr (rd_col),
        .rdata (ram_q[g])
      );
    end
  endgenerate

  // Rotate RAM outputs so lane k carries slot (head+k) mod NUM_LINES.
  always_comb begin
    lanes     = '0;
    lane_slot = '0;
    for (int k = 0; k < NUM_LINES; k++) begin
      lane_slot = {1'b0, head} + (SW+1)'(k);
      if (lane_slot >= (SW+1)'(NUM_LINES)) lane_slot = lane_slot - (SW+1)'(NUM_LINES);
      lanes[k*PIX_W +: PIX_W] = ram_q[lane_slot[SW-1:0]];
    end
  end

  // Two-stage window pipe (RAM read, output register); both hold on a stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      win_col   <= '0;
    end else if (adv) begin
      s1_valid  <= issue;
      s1_last   <= issue && rd_col_last;
      win_valid <= s1_valid;
      win_last  <= s1_last;
      if (s1_valid) win_col <= lanes;
    end
  end

  // End-of-pass pulses and sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      intrpt     <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      intrpt     <= pass_end && !frame_end;
      frame_done <= frame_end;
      if (ovf_set) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_harris_line_window_buffer.sv
// Directed bench for the Harris line window buffer (8-pixel lines, 3-line
// window, 5-line frame, pixel = line*16 + col).
module tb_harris_line_window_buffer;

  localparam int PIX_W       = 8;
  localparam int LINE_LEN    = 8;
  localparam int NUM_LINES   = 3;
  localparam int FRAME_LINES = 5;

  logic                       clk;
  logic                       reset;
  logic [PIX_W-1:0]           pixel;
  logic                       pixel_valid;
  logic [NUM_LINES*PIX_W-1:0] win_col;
  logic                       win_valid;
  logic                       win_ready;
  logic                       win_last;
  logic                       intrpt;
  logic                       frame_done;
  logic                       overflow;

  int n_cmp = 0;
  int n_bad = 0;

  harris_line_window_buffer #(
    .PIX_W       (PIX_W),
    .LINE_LEN    (LINE_LEN),
    .NUM_LINES   (NUM_LINES),
    .FRAME_LINES (FRAME_LINES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pixel       (pixel),
    .pixel_valid (pixel_valid),
    .win_col     (win_col),
    .win_valid   (win_valid),
    .win_ready   (win_ready),
    .win_last    (win_last),
    .intrpt      (intrpt),
    .frame_done  (frame_done),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_col"},  64'(win_col),    64'h0);
    check_val({tag, "_vld"},  64'(win_valid),  64'h0);
    check_val({tag, "_last"}, 64'(win_last),   64'h0);
    check_val({tag, "_int"},  64'(intrpt),     64'h0);
    check_val({tag, "_fd"},   64'(frame_done), 64'h0);
    check_val({tag, "_ovf"},  64'(overflow),   64'h0);
  endtask

  task automatic send_pixels(input int line, input int count);
    for (int c = 0; c < count; c++) begin
      @(negedge clk);
      pixel       = 8'(line * 16 + c);
      pixel_valid = 1'b1;
    end
    @(negedge clk);
    pixel_valid = 1'b0;
  endtask

  // Expected window for column c when line l0 is the oldest line held.
  function automatic logic [23:0] exp_col(input int l0, input int c);
    return {8'((l0 + 2) * 16 + c), 8'((l0 + 1) * 16 + c), 8'(l0 * 16 + c)};
  endfunction

  // Collect one full pass; toggle=1 alternates win_ready each cycle.
  task automatic collect_pass(input int l0, input bit toggle, input string tag);
    int beats = 0;
    int cyc = 0;
    bit prev_stall = 1'b0;
    logic [23:0] prev_col = '0;
    bit rdy;
    while (beats < LINE_LEN && cyc < 200) begin
      rdy = toggle ? bit'(cyc % 2) : 1'b1;
      win_ready = rdy;
      #1;
      if (win_valid) begin
        if (prev_stall) check_val({tag, "_hold"}, 64'(win_col), 64'(prev_col));
        if (rdy) begin
          check_val({tag, "_col"},  64'(win_col),  64'(exp_col(l0, beats)));
          check_val({tag, "_last"}, 64'(win_last), 64'(beats == LINE_LEN - 1));
          beats++;
        end
      end
      prev_stall = win_valid && !rdy;
      prev_col   = win_col;
      @(negedge clk);
      cyc++;
    end
    if (beats < LINE_LEN) check_val({tag, "_timeout"}, 64'(beats), 64'(LINE_LEN));
    win_ready = 1'b1;
  endtask

  initial begin
    reset       = 1'b0;
    pixel       = '0;
    pixel_valid = 1'b0;
    win_ready   = 1'b1;
    #12;
    check_idle_outputs("rst");
    @(negedge clk);
    reset = 1'b1;

    // Fill, first-window latency, straight pass.
    send_pixels(0, LINE_LEN);
    send_pixels(1, LINE_LEN);
    send_pixels(2, LINE_LEN);
    check_val("lat_c0", 64'(win_valid), 64'h0);
    @(negedge clk);
    check_val("lat_c1", 64'(win_valid), 64'h0);
    @(negedge clk);
    check_val("lat_c2", 64'(win_valid), 64'h1);
    collect_pass(0, 1'b0, "p1");
    check_val("p1_vld_off", 64'(win_valid), 64'h0);
    check_val("p1_int_hi", 64'(intrpt), 64'h1);
    @(negedge clk);
    check_val("p1_int_lo", 64'(intrpt), 64'h0);

    // Rotated window (head=1) with a toggling ready.
    send_pixels(3, LINE_LEN);
    collect_pass(1, 1'b1, "p2");
    check_val("p2_int_hi", 64'(intrpt), 64'h1);
    @(negedge clk);
    check_val("p2_int_lo", 64'(intrpt), 64'h0);

    // Last pass of the frame, with dropped pixels during SCAN.
    win_ready = 1'b0;
    send_pixels(4, LINE_LEN);
    for (int i = 0; i < 3; i++) begin
      pixel       = 8'hFF;
      pixel_valid = 1'b1;
      @(negedge clk);
    end
    pixel_valid = 1'b0;
    check_val("ovf_set", 64'(overflow), 64'h1);
    collect_pass(2, 1'b0, "p3");
    check_val("p3_fd_hi", 64'(frame_done), 64'h1);
    check_val("p3_no_int", 64'(intrpt), 64'h0);
    @(negedge clk);
    check_val("p3_fd_lo", 64'(frame_done), 64'h0);
    check_val("p3_no_int2", 64'(intrpt), 64'h0);
    check_val("ovf_sticky", 64'(overflow), 64'h1);

    // Second frame restarts from FILL.
    send_pixels(0, LINE_LEN);
    send_pixels(1, LINE_LEN);
    send_pixels(2, LINE_LEN);
    collect_pass(0, 1'b0, "f2");
    check_val("f2_int_hi", 64'(intrpt), 64'h1);
    check_val("f2_ovf", 64'(overflow), 64'h1);

    // Reset in the middle of a LOAD.
    send_pixels(3, 4);
    reset = 1'b0;
    #1;
    check_idle_outputs("mid_rst");
    @(negedge clk);
    reset = 1'b1;
    send_pixels(0, LINE_LEN);
    send_pixels(1, LINE_LEN);
    send_pixels(2, LINE_LEN);
    collect_pass(0, 1'b0, "r1");
    check_val("r1_int_hi", 64'(intrpt), 64'h1);
    check_val("r1_ovf", 64'(overflow), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
